// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the push-button FIFO pointer controller.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ISSUE    = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DEB_CYC = 2;
  localparam int DATA_W      = 15;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer for the raw active-low button plus a run-length counter
// that flags when the synchronized level has held steady for DEB_CYC clocks.
module btn_debounce
  import fifo_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clock,
  input  logic resetN,
  input  logic button,
  output logic btn_lvl,
  output logic btn_stable
);

  localparam int RUN_W = $clog2(DEB_CYC + 1);

  logic             meta_q;
  logic             sync_q;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W-1:0] run_q;

  // run_q counts consecutive clocks sync_q has held its current level, saturating.
  always_comb begin
    run_d = run_q;
    if (meta_q != sync_q) begin
      run_d = RUN_W'(1);
    end else if (run_q != RUN_W'(DEB_CYC)) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      run_q  <= RUN_W'(DEB_CYC);
    end else begin
      meta_q <= button;
      sync_q <= meta_q;
      run_q  <= run_d;
    end
  end

  assign btn_lvl    = sync_q;
  assign btn_stable = (run_q == RUN_W'(DEB_CYC));

endmodule

// File: rtl/fifo_ctrl.sv
// Push-button driven FIFO pointer controller: one debounced press issues one RAM
// write or read strobe. Define FIFO_CTRL_ERRCNT_EN to build the refused-operation counter.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              button,
  input  logic              wren,
  output logic              wen,
  output logic              ren,
  output logic [ADDR_W-1:0] wrAdd,
  output logic [ADDR_W-1:0] rdAdd,
  output logic              full,
  output logic              empty,
  output logic              blocked,
  output logic [7:0]        errCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              btn_lvl;
  logic              btn_stable;

  state_e            state_d, state_q;
  logic [PTR_W-1:0]  wptr_d, wptr_q;
  logic [PTR_W-1:0]  rptr_d, rptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              wen_d, wen_q;
  logic              ren_d, ren_q;
  logic              blocked_d, blocked_q;
  logic [ADDR_W-1:0] wr_add_d, wr_add_q;
  logic [ADDR_W-1:0] rd_add_d, rd_add_q;
  logic              full_d, full_q;
  logic              empty_d, empty_q;

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_btn_debounce (
    .clock      (clock),
    .resetN     (resetN),
    .button     (button),
    .btn_lvl    (btn_lvl),
    .btn_stable (btn_stable)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The operation is decided on entry to ISSUE (wren sampled once); pointers and
  // count advance on the edge leaving ISSUE, after the strobe has been presented.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    blocked_d = 1'b0;
    wr_add_d  = wr_add_q;
    rd_add_d  = rd_add_q;
    full_d    = (count_q == CNT_W'(DEPTH));
    empty_d   = (count_q == '0);
    unique case (state_q)
      IDLE: begin
        if (!btn_lvl) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (btn_lvl) begin
          state_d = IDLE;
        end else if (btn_stable) begin
          state_d = ISSUE;
          if (wren) begin
            if (!full_q) begin
              wen_d    = 1'b1;
              wr_add_d = ADDR_W'(wptr_q);
            end else begin
              blocked_d = 1'b1;
            end
          end else begin
            if (!empty_q) begin
              ren_d    = 1'b1;
              rd_add_d = ADDR_W'(rptr_q);
            end else begin
              blocked_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_REL;
        if (wen_q) begin
          wptr_d  = next_ptr(wptr_q);
          count_d = count_q + 1'b1;
        end
        if (ren_q) begin
          rptr_d  = next_ptr(rptr_q);
          count_d = count_q - 1'b1;
        end
      end
      WAIT_REL: begin
        if (btn_lvl && btn_stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      blocked_q <= 1'b0;
      wr_add_q  <= '0;
      rd_add_q  <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      blocked_q <= blocked_d;
      wr_add_q  <= wr_add_d;
      rd_add_q  <= rd_add_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign wen     = wen_q;
  assign ren     = ren_q;
  assign blocked = blocked_q;
  assign wrAdd   = wr_add_q;
  assign rdAdd   = rd_add_q;
  assign full    = full_q;
  assign empty   = empty_q;

`ifdef FIFO_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_d, err_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (blocked_q) err_cnt_d = sat_inc8(err_cnt_q);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign errCount = err_cnt_q;
`else
  assign errCount = '0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed press sequences plus randomized presses, all
// compared against an occupancy/pointer model of the FIFO.
module tb_fifo_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              resetN;
  logic              button;
  logic              wren;
  logic              wen;
  logic              ren;
  logic [ADDR_W-1:0] wrAdd;
  logic [ADDR_W-1:0] rdAdd;
  logic              full;
  logic              empty;
  logic              blocked;
  logic [7:0]        errCount;

  fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DEB_CYC(2)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .button   (button),
    .wren     (wren),
    .wen      (wen),
    .ren      (ren),
    .wrAdd    (wrAdd),
    .rdAdd    (rdAdd),
    .full     (full),
    .empty    (empty),
    .blocked  (blocked),
    .errCount (errCount)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe monitor, sampled on the falling edge.
  int n_wen = 0, n_ren = 0, n_blk = 0, n_both = 0;
  int last_wr = 0, last_rd = 0;
  always @(negedge clock) begin
    if (wen) begin n_wen++; last_wr = int'(wrAdd); end
    if (ren) begin n_ren++; last_rd = int'(rdAdd); end
    if (blocked) n_blk++;
    if (wen && ren) n_both++;
  end

  // Reference model: occupancy and the next read/write slots.
  int m_cnt, m_wp, m_rp, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef FIFO_CTRL_ERRCNT_EN
    return (m_err > 255) ? 255 : m_err;
`else
    return 0;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_full"}, 32'(full), 32'(m_cnt == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(m_cnt == 0));
    check({tag, "_errCount"}, 32'(errCount), 32'(exp_err()));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wen"}, 32'(wen), 0);
    check({tag, "_ren"}, 32'(ren), 0);
    check({tag, "_blocked"}, 32'(blocked), 0);
    check({tag, "_wrAdd"}, 32'(wrAdd), 0);
    check({tag, "_rdAdd"}, 32'(rdAdd), 0);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_errCount"}, 32'(errCount), 0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    m_cnt = 0; m_wp = 0; m_rp = 0; m_err = 0;
    check_reset_values("reset");
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // One press: button low for `hold` clocks; wren optionally scrambled once it has been sampled.
  task automatic press(input bit wr, input int hold, input bit scramble, input string tag);
    int w0, r0, b0, x0;
    bit exp_w, exp_r, exp_b;
    w0 = n_wen; r0 = n_ren; b0 = n_blk; x0 = n_both;
    exp_w = wr && (m_cnt < DEPTH);
    exp_r = !wr && (m_cnt > 0);
    exp_b = !(exp_w || exp_r);
    wren   = wr;
    button = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      if (scramble && i >= 6) wren = 1'($urandom_range(0, 1));
    end
    button = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check({tag, "_wen_cnt"}, 32'(n_wen - w0), 32'(exp_w));
    check({tag, "_ren_cnt"}, 32'(n_ren - r0), 32'(exp_r));
    check({tag, "_blk_cnt"}, 32'(n_blk - b0), 32'(exp_b));
    check({tag, "_excl"}, 32'(n_both - x0), 0);
    if (exp_w) begin
      check({tag, "_wrAdd"}, 32'(last_wr), 32'(m_wp));
      m_wp = (m_wp + 1) % DEPTH;
      m_cnt++;
    end
    if (exp_r) begin
      check({tag, "_rdAdd"}, 32'(last_rd), 32'(m_rp));
      m_rp = (m_rp + 1) % DEPTH;
      m_cnt--;
    end
    if (exp_b) m_err++;
    check_idle_outputs(tag);
  endtask

  task automatic glitch(input string tag);
    int w0, r0, b0;
    w0 = n_wen; r0 = n_ren; b0 = n_blk;
    button = 1'b0;
    @(posedge clock);
    #1 button = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check({tag, "_wen_cnt"}, 32'(n_wen - w0), 0);
    check({tag, "_ren_cnt"}, 32'(n_ren - r0), 0);
    check({tag, "_blk_cnt"}, 32'(n_blk - b0), 0);
  endtask

  initial begin
    int w0, r0, b0;
    resetN = 1'b0;
    button = 1'b1;
    wren   = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < DEPTH; i++) press(1'b1, 10, 1'b0, "fill");
    press(1'b1, 10, 1'b0, "overfill");
    for (int i = 0; i < DEPTH; i++) press(1'b0, 10, 1'b0, "drain");
    press(1'b0, 10, 1'b0, "underflow");

    // Short glitch ignored, long hold gives a single operation.
    glitch("glitch");
    press(1'b1, 50, 1'b0, "longhold");

    // Pointer wrap: write 5, read 5, write 5.
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b1, 9, 1'b1, "wrap_w1");
    for (int i = 0; i < 5; i++) press(1'b0, 9, 1'b1, "wrap_r");
    for (int i = 0; i < 5; i++) press(1'b1, 9, 1'b1, "wrap_w2");
    check("wrap_last_wrAdd", 32'(last_wr), 1);
    check("wrap_count", 32'(m_cnt), 5);

    // Reset while the press is being debounced.
    w0 = n_wen; r0 = n_ren; b0 = n_blk;
    wren   = 1'b1;
    button = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetN = 1'b0;
    button = 1'b1;
    #1;
    m_cnt = 0; m_wp = 0; m_rp = 0; m_err = 0;
    check_reset_values("midreset");
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    check("midreset_wen_cnt", 32'(n_wen - w0), 0);
    check("midreset_ren_cnt", 32'(n_ren - r0), 0);
    check("midreset_blk_cnt", 32'(n_blk - b0), 0);
    check_reset_values("midreset_after");

    // Randomized presses and glitches.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) glitch("rand_glitch");
      press(1'($urandom_range(0, 99) < 55), int'($urandom_range(8, 20)), 1'b1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
